// File: rtl/lane_serializer.sv
// Word-to-lane serializer: accepts one packed word of N lanes and streams
// lanes 0..in_count out one per cycle, both sides under valid/ready.

module mux_n_1 #(
  parameter int WIDTH  = 8,
  parameter int LOG2_N = 2
) (
  input  logic [LOG2_N-1:0]          sel,
  input  logic [(WIDTH<<LOG2_N)-1:0] data,
  output logic [WIDTH-1:0]           y
);

  // NOTE: assign a default before any conditional write in always_comb so no path leaves y unassigned (latch).
  always_comb begin
    y = '0;
    for (int k = 0; k < (1 << LOG2_N); k++) begin
      if (sel == k[LOG2_N-1:0]) y = data[k*WIDTH +: WIDTH];
    end
  end

endmodule

module lane_serializer #(
  parameter  int WIDTH    = 8,
  parameter  int LOG2_N   = 2,
  localparam int N        = 1 << LOG2_N,
  localparam int IN_WIDTH = N * WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic [LOG2_N-1:0]   in_count,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [LOG2_N-1:0]   out_sel,
  output logic                out_last
);

  logic [IN_WIDTH-1:0] word_q,     word_d;
  logic [LOG2_N-1:0]   last_idx_q, last_idx_d;
  logic [LOG2_N-1:0]   sel_q,      sel_d;
  logic                busy_q,     busy_d;
  logic                in_fire, out_fire;

  // NOTE: state registers use non-blocking assignments only; word_q is reset too, so out_data reads 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q     <= '0;
      last_idx_q <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      word_q     <= word_d;
      last_idx_q <= last_idx_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
    end
  end

  // A new word wins over advancing/finishing the current one, which lets
  // the last lane and the next word share a cycle.
  always_comb begin
    word_d     = word_q;
    last_idx_d = last_idx_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    if (in_fire) begin
      word_d     = in_data;
      last_idx_d = in_count;
      sel_d      = '0;
      busy_d     = 1'b1;
    end else if (out_fire && !out_last) begin
      sel_d      = sel_q + 1'b1;
    end else if (out_fire && out_last) begin
      busy_d     = 1'b0;
    end
  end

  always_comb begin
    out_valid = busy_q;
    out_sel   = sel_q;
    out_last  = busy_q && (sel_q == last_idx_q);
    out_fire  = out_valid && out_ready;
    in_ready  = !busy_q || (out_fire && out_last);
    in_fire   = in_valid && in_ready;
  end

  mux_n_1 #(
    .WIDTH  (WIDTH),
    .LOG2_N (LOG2_N)
  ) u_mux (
    .sel  (sel_q),
    .data (word_q),
    .y    (out_data)
  );

endmodule

// File: tb/tb_lane_serializer.sv
// Directed self-checking bench for lane_serializer (WIDTH=8, four lanes per word).

module tb_lane_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_count;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_last;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-derived lane values of the two test words, lane 0 first.
  logic [7:0] lanes_a [4] = '{8'h0d, 8'h0c, 8'h0b, 8'h0a};
  logic [7:0] lanes_b [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
  // Backpressure: out_ready pattern and the lane index presented each cycle.
  logic       bp_ready [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int         bp_sel   [8] = '{0, 1, 1, 1, 2, 3, 3, 3};

  lane_serializer #(.WIDTH(8), .LOG2_N(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lane(input string tag, input logic [7:0] data, input int sel,
                            input logic last, input logic rdy);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"},  out_data,  data);
    check({tag, "_sel"},   out_sel,   sel);
    check({tag, "_last"},  out_last,  last);
    check({tag, "_ready"}, in_ready,  rdy);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_last"},  out_last,  1'b0);
    check({tag, "_ready"}, in_ready,  1'b1);
  endtask

  // Offer a word while idle, confirm it is accepted, then drop in_valid.
  task automatic load_word(input string tag, input logic [31:0] data, input logic [1:0] count);
    in_valid = 1'b1;
    in_data  = data;
    in_count = count;
    #1;
    check({tag, "_accept"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_count  = '0;
    out_ready = 1'b0;
    #2;
    check_idle("reset");
    check("reset_sel",  out_sel,  2'd0);
    check("reset_data", out_data, 8'h00);
    #10 reset_n = 1'b1;
    step();
    step();
    check_idle("idle_hold");

    // Single full word.
    out_ready = 1'b1;
    load_word("single", 32'h0a0b0c0d, 2'd3);
    for (int i = 0; i < 4; i++) begin
      check_lane($sformatf("single_l%0d", i), lanes_a[i], i, i == 3, i == 3);
      step();
    end
    check_idle("single_done");

    // Partial words: one lane, then two lanes.
    load_word("part0", 32'h0a0b0c0d, 2'd0);
    check_lane("part0_l0", 8'h0d, 0, 1'b1, 1'b1);
    step();
    check_idle("part0_done");
    load_word("part1", 32'h0a0b0c0d, 2'd1);
    check_lane("part1_l0", 8'h0d, 0, 1'b0, 1'b0);
    step();
    check_lane("part1_l1", 8'h0c, 1, 1'b1, 1'b1);
    step();
    check_idle("part1_done");

    // Back-to-back words with in_valid held: eight lanes, no bubble.
    in_valid = 1'b1;
    in_data  = 32'h0a0b0c0d;
    in_count = 2'd3;
    #1;
    check("b2b_first_ready", in_ready, 1'b1);
    step();
    in_data = 32'h11223344;
    for (int i = 0; i < 4; i++) begin
      check_lane($sformatf("b2b_a%0d", i), lanes_a[i], i, i == 3, i == 3);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_lane($sformatf("b2b_b%0d", i), lanes_b[i], i, i == 3, i == 3);
      step();
    end
    check_idle("b2b_done");

    // Backpressure: lanes held stable while out_ready is low.
    load_word("bp", 32'h0a0b0c0d, 2'd3);
    for (int c = 0; c < 8; c++) begin
      out_ready = bp_ready[c];
      #1;
      check_lane($sformatf("bp_c%0d", c), lanes_a[bp_sel[c]], bp_sel[c],
                 bp_sel[c] == 3, bp_ready[c] && (bp_sel[c] == 3));
      step();
    end
    out_ready = 1'b1;
    #1;
    check_idle("bp_done");

    // Inputs changing mid-word are ignored.
    load_word("chg", 32'h0a0b0c0d, 2'd3);
    check_lane("chg_l0", 8'h0d, 0, 1'b0, 1'b0);
    in_data  = 32'hdeadbeef;
    in_count = 2'd0;
    step();
    for (int i = 1; i < 4; i++) begin
      check_lane($sformatf("chg_l%0d", i), lanes_a[i], i, i == 3, i == 3);
      step();
    end
    check_idle("chg_done");

    // Reset mid-word after lane 0x0c fires.
    load_word("rst", 32'h0a0b0c0d, 2'd3);
    check_lane("rst_l0", 8'h0d, 0, 1'b0, 1'b0);
    step();
    check_lane("rst_l1", 8'h0c, 1, 1'b0, 1'b0);
    step();
    reset_n = 1'b0;
    #1;
    check_idle("rst_assert");
    check("rst_assert_data", out_data, 8'h00);
    step();
    #3 reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check_idle($sformatf("rst_after%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
